// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BURST_W   = 2;
  localparam int unsigned BURST_MAX = 3;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_LDR = 1'b1} port_t;

  typedef logic [BURST_W-1:0] burst_t;

  // Registered copy of the granted requester's access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              word_we;
    logic              byte_we;
    logic              lock;
  } acc_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_CPU) ? PORT_LDR : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signals of the arbiter, bundled with modports.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic              cpu_req;
  logic              ldr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] ldr_wdata;
  logic              cpu_word_we;
  logic              cpu_byte_we;
  logic              ldr_word_we;
  logic              ldr_byte_we;
  logic              cpu_lock;
  logic              ldr_lock;
  logic              cpu_done;
  logic              ldr_done;
  logic              cpu_err;
  logic              ldr_err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_word_we;
  logic              mem_byte_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_stall;

  modport slave (
    input  cpu_req, ldr_req, cpu_addr, ldr_addr, cpu_wdata, ldr_wdata,
           cpu_word_we, cpu_byte_we, ldr_word_we, ldr_byte_we,
           cpu_lock, ldr_lock, mem_rdata,
    output cpu_done, ldr_done, cpu_err, ldr_err, rdata,
           mem_addr, mem_wdata, mem_word_we, mem_byte_we, cpu_stall
  );

  modport master (
    output cpu_req, ldr_req, cpu_addr, ldr_addr, cpu_wdata, ldr_wdata,
           cpu_word_we, cpu_byte_we, ldr_word_we, ldr_byte_we,
           cpu_lock, ldr_lock, mem_rdata,
    input  cpu_done, ldr_done, cpu_err, ldr_err, rdata,
           mem_addr, mem_wdata, mem_word_we, mem_byte_we, cpu_stall
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes away from last_owner.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
  input  port_t last_owner,
  output logic  valid_c,
  output port_t grant_c
);

  always_comb begin
    valid_c = req0 | req1;
    grant_c = PORT_CPU;
    if (req0 && req1) begin
      grant_c = other_port(last_owner);
    end else if (req1) begin
      grant_c = PORT_LDR;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and loader accesses onto one data memory, one access per BUSY cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  state_t state, state_nxt;
  port_t  owner, owner_nxt;
  port_t  last_owner, last_nxt;
  burst_t burst_cnt, burst_nxt;
  acc_t   acc, acc_nxt;

  acc_t   cpu_acc_c, ldr_acc_c;
  logic   pick_valid_c;
  port_t  pick_c;
  logic   busy_c;
  logic   misaligned_c;

  always_comb begin
    cpu_acc_c = '{addr: bus.cpu_addr, wdata: bus.cpu_wdata, word_we: bus.cpu_word_we,
                  byte_we: bus.cpu_byte_we, lock: bus.cpu_lock};
    ldr_acc_c = '{addr: bus.ldr_addr, wdata: bus.ldr_wdata, word_we: bus.ldr_word_we,
                  byte_we: bus.ldr_byte_we, lock: bus.ldr_lock};
  end

  rr_pick2 u_pick (
    .req0       (bus.cpu_req),
    .req1       (bus.ldr_req),
    .last_owner (last_owner),
    .valid_c    (pick_valid_c),
    .grant_c    (pick_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= PORT_CPU;
      last_owner <= PORT_LDR;
      burst_cnt  <= '0;
      acc        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      burst_cnt  <= burst_nxt;
      acc        <= acc_nxt;
    end
  end

  // A locked owner keeps priority by parking last_owner on the other port, up to BURST_MAX times.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    burst_nxt = burst_cnt;
    acc_nxt   = acc;
    case (state)
      ST_IDLE: begin
        if (pick_valid_c) begin
          state_nxt = ST_BUSY;
          owner_nxt = pick_c;
          acc_nxt   = (pick_c == PORT_LDR) ? ldr_acc_c : cpu_acc_c;
        end
      end
      ST_BUSY: begin
        state_nxt = ST_IDLE;
        if (acc.lock && (burst_cnt < burst_t'(BURST_MAX))) begin
          last_nxt  = other_port(owner);
          burst_nxt = burst_cnt + burst_t'(1);
        end else begin
          last_nxt  = owner;
          burst_nxt = '0;
        end
      end
    endcase
  end

  assign busy_c       = (state == ST_BUSY);
  assign misaligned_c = acc.word_we && (acc.addr[1:0] != 2'b00);

  assign bus.cpu_done    = busy_c && (owner == PORT_CPU);
  assign bus.ldr_done    = busy_c && (owner == PORT_LDR);
  assign bus.cpu_err     = bus.cpu_done && misaligned_c;
  assign bus.ldr_err     = bus.ldr_done && misaligned_c;
  assign bus.mem_addr    = acc.addr;
  assign bus.mem_wdata   = acc.wdata;
  assign bus.mem_word_we = busy_c && acc.word_we && !misaligned_c;
  assign bus.mem_byte_we = busy_c && acc.byte_we;
  assign bus.rdata       = busy_c ? bus.mem_rdata : '0;
  assign bus.cpu_stall   = bus.cpu_req && !bus.cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, grant-order sequences, reset abort, random run.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        port;
    logic        word_we;
    logic        byte_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        exp_wwe;
    logic        exp_bwe;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];
  int   got_own[$];
  int   got_cyc[$];

  // Random-phase requester state and reference model
  bit          act[2];
  logic [31:0] ra[2];
  logic [31:0] rw[2];
  bit          rwwe[2];
  bit          rbwe[2];
  bit          rlk[2];

  task automatic chk1(input string nm, input logic act_v, input logic exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", nm, act_v, exp_v);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act_v, exp_v);
    end
  endtask

  task automatic set_port(input logic p, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic wwe, input logic bwe, input logic lk);
    if (p == 1'b0) begin
      bus.cpu_req = r; bus.cpu_addr = a; bus.cpu_wdata = d;
      bus.cpu_word_we = wwe; bus.cpu_byte_we = bwe; bus.cpu_lock = lk;
    end else begin
      bus.ldr_req = r; bus.ldr_addr = a; bus.ldr_wdata = d;
      bus.ldr_word_we = wwe; bus.ldr_byte_we = bwe; bus.ldr_lock = lk;
    end
  endtask

  task automatic drive_idle();
    set_port(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_port(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    bus.mem_rdata = 32'hFFFF_FFFF;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk1("rst.cpu_done", bus.cpu_done, 1'b0);
    chk1("rst.ldr_done", bus.ldr_done, 1'b0);
    chk1("rst.err", bus.cpu_err | bus.ldr_err, 1'b0);
    chk1("rst.mem_we", bus.mem_word_we | bus.mem_byte_we, 1'b0);
    chk32("rst.mem_addr", bus.mem_addr, 32'h0);
    chk32("rst.mem_wdata", bus.mem_wdata, 32'h0);
    chk32("rst.rdata", bus.rdata, 32'h0);
    bus.mem_rdata = 32'h0;
    reset = 1'b1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clock);
    chk1($sformatf("v%0d.idle_done", i), bus.cpu_done | bus.ldr_done, 1'b0);
    chk1($sformatf("v%0d.idle_we", i), bus.mem_word_we | bus.mem_byte_we, 1'b0);
    chk32($sformatf("v%0d.idle_rdata", i), bus.rdata, 32'h0);
    set_port(v.port, 1'b1, v.addr, v.wdata, v.word_we, v.byte_we, 1'b0);
    bus.mem_rdata = v.mrd;
    #1 chk1($sformatf("v%0d.stall_wait", i), bus.cpu_stall, v.port == 1'b0);
    @(negedge clock);
    chk1($sformatf("v%0d.cpu_done", i), bus.cpu_done, v.port == 1'b0);
    chk1($sformatf("v%0d.ldr_done", i), bus.ldr_done, v.port == 1'b1);
    chk1($sformatf("v%0d.cpu_err", i), bus.cpu_err, (v.port == 1'b0) && v.exp_err);
    chk1($sformatf("v%0d.ldr_err", i), bus.ldr_err, (v.port == 1'b1) && v.exp_err);
    chk1($sformatf("v%0d.word_we", i), bus.mem_word_we, v.exp_wwe);
    chk1($sformatf("v%0d.byte_we", i), bus.mem_byte_we, v.exp_bwe);
    chk32($sformatf("v%0d.mem_addr", i), bus.mem_addr, v.addr);
    chk32($sformatf("v%0d.mem_wdata", i), bus.mem_wdata, v.wdata);
    chk32($sformatf("v%0d.rdata", i), bus.rdata, v.mrd);
    chk1($sformatf("v%0d.stall_done", i), bus.cpu_stall, 1'b0);
    drive_idle();
  endtask

  // Hold both requests until n completions are seen; record owner and cycle of each done.
  task automatic run_both(input int n, input logic lk);
    got_own.delete();
    got_cyc.delete();
    @(negedge clock);
    set_port(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    set_port(1'b1, 1'b1, 32'h200, 32'h0, 1'b0, 1'b0, lk);
    for (int c = 1; c <= 4 * n + 4 && got_own.size() < n; c++) begin
      @(negedge clock);
      if (bus.cpu_done) begin got_own.push_back(0); got_cyc.push_back(c); end
      if (bus.ldr_done) begin got_own.push_back(1); got_cyc.push_back(c); end
    end
    drive_idle();
    if (got_own.size() < n) chk32("run_both.timeout", 32'(got_own.size()), 32'(n));
  endtask

  task automatic new_payload(input int p);
    int kind;
    kind    = $urandom_range(0, 2);
    ra[p]   = $urandom;
    rw[p]   = $urandom;
    rwwe[p] = (kind == 1);
    rbwe[p] = (kind == 2);
    rlk[p]  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic random_run(input int ncyc);
    int          lo, bc, mown;
    bit          mbusy, mis, ecd, eld;
    logic [31:0] m_addr, m_wdata, cur_mrd;
    bit          m_wwe, m_bwe, m_lock;
    lo = 1; bc = 0; mbusy = 0; mown = 0;
    m_addr = 0; m_wdata = 0; m_wwe = 0; m_bwe = 0; m_lock = 0; cur_mrd = 0;
    act[0] = 0; act[1] = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clock);
      ecd = mbusy && (mown == 0);
      eld = mbusy && (mown == 1);
      mis = m_wwe && (m_addr[1:0] != 2'b00);
      chk1("rnd.cpu_done", bus.cpu_done, ecd);
      chk1("rnd.ldr_done", bus.ldr_done, eld);
      chk1("rnd.cpu_err", bus.cpu_err, ecd && mis);
      chk1("rnd.ldr_err", bus.ldr_err, eld && mis);
      chk1("rnd.word_we", bus.mem_word_we, mbusy && m_wwe && !mis);
      chk1("rnd.byte_we", bus.mem_byte_we, mbusy && m_bwe);
      chk32("rnd.rdata", bus.rdata, mbusy ? cur_mrd : 32'h0);
      chk1("rnd.stall", bus.cpu_stall, act[0] && !ecd);
      if (mbusy) begin
        chk32("rnd.mem_addr", bus.mem_addr, m_addr);
        chk32("rnd.mem_wdata", bus.mem_wdata, m_wdata);
      end
      // Requesters: after done either renew or drop; idle ones may raise a new request.
      for (int p = 0; p < 2; p++) begin
        if (mbusy && mown == p) begin
          act[p] = ($urandom_range(0, 1) == 1);
          if (act[p]) new_payload(p);
        end else if (!act[p] && $urandom_range(0, 4) < 2) begin
          act[p] = 1;
          new_payload(p);
        end
        set_port(p[0], act[p], ra[p], rw[p], rwwe[p], rbwe[p], rlk[p]);
      end
      cur_mrd = $urandom;
      bus.mem_rdata = cur_mrd;
      // Model: a completion updates priority; an idle arbiter grants on the coming edge.
      if (mbusy) begin
        if (m_lock && bc < 3) begin lo = 1 - mown; bc = bc + 1; end
        else begin lo = mown; bc = 0; end
        mbusy = 0;
      end else if (act[0] || act[1]) begin
        mown    = (act[0] && act[1]) ? (1 - lo) : (act[1] ? 1 : 0);
        m_addr  = ra[mown]; m_wdata = rw[mown];
        m_wwe   = rwwe[mown]; m_bwe = rbwe[mown]; m_lock = rlk[mown];
        mbusy   = 1;
      end
    end
    drive_idle();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h6,  32'h1234,     32'h0,        1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h3,  32'hAB,       32'h0,        1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h1,  32'h5555AAAA, 32'h0,        1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0,        32'h000055AA, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b0};

    do_reset();

    // Tie from reset: CPU first, then alternate, two cycles apart.
    run_both(4, 1'b0);
    for (int i = 0; i < got_own.size() && i < 4; i++) begin
      chk32($sformatf("tie.owner%0d", i), 32'(got_own[i]), 32'(i % 2));
      chk32($sformatf("tie.cycle%0d", i), 32'(got_cyc[i]), 32'(2 * i + 1));
    end

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Last table access was the CPU, so a locked loader takes four grants in a row.
    run_both(10, 1'b1);
    for (int i = 0; i < got_own.size() && i < 10; i++) begin
      chk32($sformatf("lock.owner%0d", i), 32'(got_own[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
      chk32($sformatf("lock.cycle%0d", i), 32'(got_cyc[i]), 32'(2 * i + 1));
    end

    // Reset during the BUSY cycle of a CPU word store.
    @(negedge clock);
    set_port(1'b0, 1'b1, 32'h20, 32'h11223344, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1 chk1("abort.we_before", bus.mem_word_we, 1'b1);
    reset = 1'b0;
    #1;
    chk1("abort.we_after", bus.mem_word_we, 1'b0);
    chk1("abort.done", bus.cpu_done, 1'b0);
    chk1("abort.state_idle", dut.state == ST_IDLE, 1'b1);
    chk32("abort.mem_addr", bus.mem_addr, 32'h0);
    drive_idle();
    @(negedge clock);
    chk1("abort.no_done", bus.cpu_done | bus.ldr_done, 1'b0);
    reset = 1'b1;

    // Reset restores last_owner to the loader, so a tie goes to the CPU.
    run_both(1, 1'b0);
    if (got_own.size() > 0) begin
      chk32("post_rst.owner", 32'(got_own[0]), 32'd0);
      chk32("post_rst.cycle", 32'(got_cyc[0]), 32'd1);
    end

    do_reset();
    random_run(800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
